// File: rtl/time12_pkg.sv
// Shared types and constants for the 12-hour time setter and its helpers.
// Holds the FSM state encoding, field ranges and field_sel codes.
package time12_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_EDIT_HOUR = 3'd1,
        ST_EDIT_MIN  = 3'd2,
        ST_EDIT_AMPM = 3'd3,
        ST_COMMIT    = 3'd4
    } state_t;

    localparam logic [3:0] HOUR_MIN = 4'd1;
    localparam logic [3:0] HOUR_MAX = 4'd12;
    localparam logic [5:0] MIN_MAX  = 6'd59;

    localparam logic [1:0] FIELD_NONE = 2'd0;
    localparam logic [1:0] FIELD_HOUR = 2'd1;
    localparam logic [1:0] FIELD_MIN  = 2'd2;
    localparam logic [1:0] FIELD_AMPM = 2'd3;

    // True in any of the three edit states.
    function automatic logic is_edit(input state_t s);
        return (s == ST_EDIT_HOUR) || (s == ST_EDIT_MIN) || (s == ST_EDIT_AMPM);
    endfunction

    // Field selector code shown to the display for a given state.
    function automatic logic [1:0] field_of(input state_t s);
        logic [1:0] f;
        case (s)
            ST_EDIT_HOUR: f = FIELD_HOUR;
            ST_EDIT_MIN:  f = FIELD_MIN;
            ST_EDIT_AMPM: f = FIELD_AMPM;
            default:      f = FIELD_NONE;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/hour12_to_24.sv
// Combinational 12-hour to 24-hour converter.
// 12 AM maps to 0, 12 PM to 12, other PM hours gain 12.
module hour12_to_24
    import time12_pkg::*;
(
    input  logic       i_isPM,
    input  logic [3:0] i_hours,
    output logic [4:0] o_hours24
);

    // Map (AM/PM, hour 1..12) onto 0..23.
    always_comb begin
        o_hours24 = {1'b0, i_hours};
        if (i_hours == HOUR_MAX) begin
            o_hours24 = i_isPM ? 5'd12 : 5'd0;
        end else if (i_isPM) begin
            o_hours24 = {1'b0, i_hours} + 5'd12;
        end
    end

endmodule

// File: rtl/time_setter12.sv
// Button-driven 12-hour time editor. Snapshots the running time on entry,
// edits hour/minute/AM-PM, and emits a one-cycle propagate strobe carrying
// both the 12-hour value and its 24-hour equivalent.
// Optional display blink is built only when TIME_SETTER_BLINK_EN is defined;
// otherwise blink is tied high.
// Handshake: every btn_* input is a single-cycle pulse sampled on the rising
// clock edge; propagate is a single-cycle registered strobe and out_* are
// stable while it is high and held afterwards. There is no back-pressure.
module time_setter12
    import time12_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1_000_000,
    parameter int BLINK_DIV      = 250_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_confirm,
    input  logic       cur_isPM,
    input  logic [3:0] cur_hours,
    input  logic [5:0] cur_minutes,
    output logic       editing,
    output logic [1:0] field_sel,
    output logic       out_PM,
    output logic [3:0] out_hours,
    output logic [5:0] out_minutes,
    output logic [4:0] out_hours24,
    output logic       propagate,
    output logic       blink,
    output state_t     o_dbg_state
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    state_t          r_state;
    state_t          w_next_state;
    logic            w_in_edit;
    logic            w_any_btn;
    logic            w_timeout_hit;
    logic            w_load;
    logic            w_step_up;
    logic            w_step_down;
    logic [TW-1:0]   r_timeout;
    logic            r_PM;
    logic [3:0]      r_hours;
    logic [5:0]      r_minutes;
    logic            r_propagate;

    assign w_in_edit     = is_edit(r_state);
    assign w_any_btn     = btn_mode | btn_up | btn_down | btn_confirm;
    assign w_timeout_hit = w_in_edit && !w_any_btn &&
                           (r_timeout == TW'(TIMEOUT_CYCLES - 1));

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state and field-edit strobes; confirm beats mode beats up/down.
    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_step_up    = 1'b0;
        w_step_down  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (btn_mode) begin
                    w_next_state = ST_EDIT_HOUR;
                    w_load       = 1'b1;
                end
            end
            ST_EDIT_HOUR, ST_EDIT_MIN, ST_EDIT_AMPM: begin
                if (btn_confirm) begin
                    w_next_state = ST_COMMIT;
                end else if (btn_mode) begin
                    case (r_state)
                        ST_EDIT_HOUR: w_next_state = ST_EDIT_MIN;
                        ST_EDIT_MIN:  w_next_state = ST_EDIT_AMPM;
                        default:      w_next_state = ST_EDIT_HOUR;
                    endcase
                end else if (btn_up != btn_down) begin
                    w_step_up   = btn_up;
                    w_step_down = btn_down;
                end else if (w_timeout_hit) begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_COMMIT: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Idle-cycle counter; cleared by any button, any state change, or outside edit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_timeout <= '0;
        end else if (!w_in_edit || w_any_btn || (w_next_state != r_state)) begin
            r_timeout <= '0;
        end else begin
            r_timeout <= r_timeout + TW'(1);
        end
    end

    // Edited field registers: snapshot on entry, wrap-around step while editing.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_PM      <= 1'b0;
            r_hours   <= HOUR_MAX;
            r_minutes <= '0;
        end else if (w_load) begin
            r_PM      <= cur_isPM;
            r_hours   <= cur_hours;
            r_minutes <= cur_minutes;
        end else if (w_step_up || w_step_down) begin
            case (r_state)
                ST_EDIT_HOUR: begin
                    if (w_step_up) begin
                        r_hours <= (r_hours >= HOUR_MAX) ? HOUR_MIN : r_hours + 4'd1;
                    end else begin
                        r_hours <= (r_hours <= HOUR_MIN) ? HOUR_MAX : r_hours - 4'd1;
                    end
                end
                ST_EDIT_MIN: begin
                    if (w_step_up) begin
                        r_minutes <= (r_minutes >= MIN_MAX) ? 6'd0 : r_minutes + 6'd1;
                    end else begin
                        r_minutes <= (r_minutes == 6'd0) ? MIN_MAX : r_minutes - 6'd1;
                    end
                end
                ST_EDIT_AMPM: begin
                    r_PM <= ~r_PM;
                end
                default: begin
                    r_PM <= r_PM;
                end
            endcase
        end
    end

    // Propagate strobe is high exactly for the COMMIT cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_propagate <= 1'b0;
        end else begin
            r_propagate <= (w_next_state == ST_COMMIT);
        end
    end

    hour12_to_24 u_hour12_to_24 (
        .i_isPM    (r_PM),
        .i_hours   (r_hours),
        .o_hours24 (out_hours24)
    );

    assign editing     = w_in_edit;
    assign field_sel   = field_of(r_state);
    assign out_PM      = r_PM;
    assign out_hours   = r_hours;
    assign out_minutes = r_minutes;
    assign propagate   = r_propagate;
    assign o_dbg_state = r_state;

`ifdef TIME_SETTER_BLINK_EN
    localparam int BW = $clog2(BLINK_DIV + 1);

    logic          w_updown_seen;
    logic          w_blink_restart;
    logic [BW-1:0] r_blink_cnt;
    logic          r_blink;

    assign w_updown_seen   = w_in_edit && !btn_confirm && !btn_mode && (btn_up || btn_down);
    assign w_blink_restart = (w_next_state != r_state) || w_updown_seen;

    // Blink divider: restarts high on field change or up/down, toggles every BLINK_DIV cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_blink_cnt <= '0;
            r_blink     <= 1'b1;
        end else if (!is_edit(w_next_state) || w_blink_restart) begin
            r_blink_cnt <= '0;
            r_blink     <= 1'b1;
        end else if (r_blink_cnt == BW'(BLINK_DIV - 1)) begin
            r_blink_cnt <= '0;
            r_blink     <= ~r_blink;
        end else begin
            r_blink_cnt <= r_blink_cnt + BW'(1);
        end
    end

    assign blink = r_blink;
`else
    assign blink = 1'b1;
`endif

endmodule

// File: tb/tb_time_setter12.sv
// Bench for time_setter12: directed scenarios plus randomized button traffic,
// every cycle compared against a behavioural model of the time editor.
// Blink expectations follow TIME_SETTER_BLINK_EN when it is defined.
module tb_time_setter12;

    localparam int TIMEOUT = 20;
    localparam int BDIV    = 4;

    logic       clk;
    logic       reset;
    logic       btn_mode, btn_up, btn_down, btn_confirm;
    logic       cur_isPM;
    logic [3:0] cur_hours;
    logic [5:0] cur_minutes;
    logic       editing;
    logic [1:0] field_sel;
    logic       out_PM;
    logic [3:0] out_hours;
    logic [5:0] out_minutes;
    logic [4:0] out_hours24;
    logic       propagate;
    logic       blink;
    time12_pkg::state_t dbg_state;

    int n_checks = 0;
    int n_pass   = 0;
    int prop_seen;

    // model state: field 0=none 1=hour 2=min 3=ampm; commit marks the strobe cycle
    int m_field, m_commit, m_pm, m_h, m_m, m_idle, m_bt;

    time_setter12 #(.TIMEOUT_CYCLES(TIMEOUT), .BLINK_DIV(BDIV)) dut (
        .clk(clk), .reset(reset),
        .btn_mode(btn_mode), .btn_up(btn_up), .btn_down(btn_down), .btn_confirm(btn_confirm),
        .cur_isPM(cur_isPM), .cur_hours(cur_hours), .cur_minutes(cur_minutes),
        .editing(editing), .field_sel(field_sel), .out_PM(out_PM), .out_hours(out_hours),
        .out_minutes(out_minutes), .out_hours24(out_hours24), .propagate(propagate),
        .blink(blink), .o_dbg_state(dbg_state)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        m_field = 0; m_commit = 0; m_pm = 0; m_h = 12; m_m = 0; m_idle = 0; m_bt = 0;
    endtask

    // one clock edge of the editor, described in terms of the user-visible rules
    task automatic model_step(input bit m, input bit u, input bit d, input bit c);
        int old_field;
        bit restart;
        int delta;
        old_field = m_field;
        restart = (m_field != 0) && !c && !m && (u || d);
        if (m_commit) begin
            m_commit = 0;
        end else if (m_field == 0) begin
            if (m) begin
                m_field = 1; m_pm = cur_isPM; m_h = cur_hours; m_m = cur_minutes; m_idle = 0;
            end
        end else begin
            delta = (u && !d) ? 1 : ((d && !u) ? -1 : 0);
            if (c) begin
                m_field = 0; m_commit = 1;
            end else if (m) begin
                m_field = (m_field % 3) + 1;
            end else if (delta != 0) begin
                if (m_field == 1) m_h = ((m_h - 1 + delta + 12) % 12) + 1;
                else if (m_field == 2) m_m = (m_m + delta + 60) % 60;
                else m_pm = 1 - m_pm;
            end
            if (m || u || d || c) m_idle = 0;
            else begin
                m_idle++;
                if (m_idle == TIMEOUT) begin
                    m_field = 0; m_idle = 0;
                end
            end
        end
        if (restart || (m_field != old_field)) m_bt = 0;
        else m_bt++;
    endtask

    task automatic compare_all();
        int exp_blink;
        exp_blink = 1;
`ifdef TIME_SETTER_BLINK_EN
        if (m_field != 0) exp_blink = ((m_bt / BDIV) % 2 == 0) ? 1 : 0;
`endif
        check("editing", editing, (m_field != 0) ? 1 : 0);
        check("field_sel", field_sel, m_field);
        check("out_PM", out_PM, m_pm);
        check("out_hours", out_hours, m_h);
        check("out_minutes", out_minutes, m_m);
        check("out_hours24", out_hours24, m_pm ? (m_h % 12) + 12 : (m_h % 12));
        check("propagate", propagate, m_commit);
        check("blink", blink, exp_blink);
        if (propagate) prop_seen++;
    endtask

    // drive one cycle of buttons, step the model at the edge, compare at negedge
    task automatic cycle(input bit m, input bit u, input bit d, input bit c);
        btn_mode = m; btn_up = u; btn_down = d; btn_confirm = c;
        @(posedge clk);
        model_step(m, u, d, c);
        @(negedge clk);
        compare_all();
        btn_mode = 0; btn_up = 0; btn_down = 0; btn_confirm = 0;
    endtask

    task automatic set_cur(input bit pm, input int h, input int mi);
        cur_isPM = pm; cur_hours = 4'(h); cur_minutes = 6'(mi);
    endtask

    initial begin
        reset = 0;
        btn_mode = 0; btn_up = 0; btn_down = 0; btn_confirm = 0;
        set_cur(0, 11, 58);
        model_reset();
        repeat (2) @(negedge clk);
        compare_all();
        reset = 1;

        // 11:58 AM -> 12:00 AM
        cycle(1, 0, 0, 0);
        cycle(0, 1, 0, 0);
        cycle(1, 0, 0, 0);
        cycle(0, 1, 0, 0);
        cycle(0, 1, 0, 0);
        cycle(0, 0, 0, 1);
        check("t1_prop", propagate, 1);
        check("t1_h", out_hours, 12);
        check("t1_m", out_minutes, 0);
        check("t1_h24", out_hours24, 0);
        cycle(0, 0, 0, 0);
        check("t1_prop_drop", propagate, 0);

        // hour wrap across 12 PM
        set_cur(1, 1, 30);
        cycle(1, 0, 0, 0);
        cycle(0, 0, 1, 0);
        check("t2_h24_12", out_hours24, 12);
        cycle(0, 1, 0, 0);
        cycle(0, 1, 0, 0);
        check("t2_h24_14", out_hours24, 14);
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 0);

        // minute wrap down, simultaneous up/down, confirm+mode, idle confirm
        set_cur(0, 10, 0);
        cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 0);
        cycle(0, 0, 1, 0);
        check("t3_m59", out_minutes, 59);
        cycle(0, 1, 1, 0);
        check("t3_m59_hold", out_minutes, 59);
        cycle(1, 0, 0, 1);
        check("t3_commit", propagate, 1);
        cycle(0, 0, 0, 0);
        prop_seen = 0;
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 0);
        check("t3_idle_confirm", prop_seen, 0);

        // timeout abort with blink observation
        set_cur(1, 7, 15);
        prop_seen = 0;
        cycle(1, 0, 0, 0);
        repeat (TIMEOUT - 1) cycle(0, 0, 0, 0);
        check("t4_still_edit", editing, 1);
        cycle(0, 0, 0, 0);
        check("t4_aborted", editing, 0);
        check("t4_no_prop", prop_seen, 0);

        // reset during COMMIT drops the strobe
        cycle(1, 0, 0, 0);
        cycle(0, 1, 0, 0);
        cycle(0, 0, 0, 1);
        reset = 0;
        #1;
        model_reset();
        compare_all();
        check("t5_prop", propagate, 0);
        check("t5_h", out_hours, 12);
        @(negedge clk);
        reset = 1;

        // randomized traffic with occasional idle runs long enough to time out
        for (int i = 0; i < 600; i++) begin
            set_cur($urandom_range(0, 1), $urandom_range(1, 12), $urandom_range(0, 59));
            if ($urandom_range(0, 49) == 0) begin
                repeat (TIMEOUT + 2) cycle(0, 0, 0, 0);
            end else begin
                cycle($urandom_range(0, 99) < 15, $urandom_range(0, 99) < 25,
                      $urandom_range(0, 99) < 25, $urandom_range(0, 99) < 5);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
